// File: rtl/jtag_tap_pkg.sv
// rtl/jtag_tap_pkg.sv - shared types and helpers for the sampled JTAG TAP
//
// Purpose: TAP state encoding (IEEE 1149.1 numbering, TLR = 4'hF), the
// data-register select type, default opcode/IDCODE constants and the
// 16-state next-state function.
// Ports: none (package).

package jtag_tap_pkg;

  typedef enum logic [3:0] {
    TAP_EX2_DR = 4'h0,
    TAP_EX1_DR = 4'h1,
    TAP_SH_DR  = 4'h2,
    TAP_PA_DR  = 4'h3,
    TAP_SEL_IR = 4'h4,
    TAP_UPD_DR = 4'h5,
    TAP_CAP_DR = 4'h6,
    TAP_SEL_DR = 4'h7,
    TAP_EX2_IR = 4'h8,
    TAP_EX1_IR = 4'h9,
    TAP_SH_IR  = 4'hA,
    TAP_PA_IR  = 4'hB,
    TAP_RTI    = 4'hC,
    TAP_UPD_IR = 4'hD,
    TAP_CAP_IR = 4'hE,
    TAP_TLR    = 4'hF
  } tap_state_e;

  typedef enum logic [1:0] {
    DR_BYPASS = 2'd0,
    DR_IDCODE = 2'd1,
    DR_USER   = 2'd2
  } dr_sel_e;

  localparam logic [4:0]  DEF_INSTR_IDCODE = 5'h01;
  localparam logic [4:0]  DEF_INSTR_USER   = 5'h10;
  localparam logic [31:0] DEF_IDCODE_VAL   = 32'h1000_1C0B;

  function automatic tap_state_e next_state(input tap_state_e s, input logic tms);
    tap_state_e n;
    n = TAP_TLR;
    case (s)
      TAP_TLR:    n = tms ? TAP_TLR    : TAP_RTI;
      TAP_RTI:    n = tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_DR: n = tms ? TAP_SEL_IR : TAP_CAP_DR;
      TAP_CAP_DR: n = tms ? TAP_EX1_DR : TAP_SH_DR;
      TAP_SH_DR:  n = tms ? TAP_EX1_DR : TAP_SH_DR;
      TAP_EX1_DR: n = tms ? TAP_UPD_DR : TAP_PA_DR;
      TAP_PA_DR:  n = tms ? TAP_EX2_DR : TAP_PA_DR;
      TAP_EX2_DR: n = tms ? TAP_UPD_DR : TAP_SH_DR;
      TAP_UPD_DR: n = tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_IR: n = tms ? TAP_TLR    : TAP_CAP_IR;
      TAP_CAP_IR: n = tms ? TAP_EX1_IR : TAP_SH_IR;
      TAP_SH_IR:  n = tms ? TAP_EX1_IR : TAP_SH_IR;
      TAP_EX1_IR: n = tms ? TAP_UPD_IR : TAP_PA_IR;
      TAP_PA_IR:  n = tms ? TAP_EX2_IR : TAP_PA_IR;
      TAP_EX2_IR: n = tms ? TAP_UPD_IR : TAP_SH_IR;
      TAP_UPD_IR: n = tms ? TAP_SEL_DR : TAP_RTI;
      default:    n = TAP_TLR;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_tap_sampled_in_sync.sv
// rtl/jtag_tap_sampled_in_sync.sv - oversampling synchronizer and tck edge detector
//
// Purpose: two-flop synchronizer on tck/tms/tdi/trst plus a one-flop tck
// history, producing single-cycle tck rise/fall strobes in the clk_in domain.
// Ports:
//   clk_in, reset           system clock, synchronous active-high reset
//   jtag_tck/tms/tdi/trst   asynchronous pad inputs
//   tck_rise, tck_fall      one-cycle strobes on synchronized tck edges
//   tms_s, tdi_s, trst_n_s  synchronized copies, aligned with the strobes

module jtag_in_sync (
  input  logic clk_in,
  input  logic reset,
  input  logic jtag_tck,
  input  logic jtag_tms,
  input  logic jtag_tdi,
  input  logic jtag_trst,
  output logic tck_rise,
  output logic tck_fall,
  output logic tms_s,
  output logic tdi_s,
  output logic trst_n_s
);

  // bit order: {trst, tdi, tms, tck}
  logic [3:0] meta_q;
  logic [3:0] sync_q;
  logic       tck_hist_q;

  // Reset leaves synchronized trst low, so the TAP stays in reset until
  // the pad value has propagated through both stages.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      meta_q     <= '0;
      sync_q     <= '0;
      tck_hist_q <= 1'b0;
    end else begin
      meta_q     <= {jtag_trst, jtag_tdi, jtag_tms, jtag_tck};
      sync_q     <= meta_q;
      tck_hist_q <= sync_q[0];
    end
  end

  assign tck_rise = sync_q[0] & ~tck_hist_q;
  assign tck_fall = ~sync_q[0] & tck_hist_q;
  assign tms_s    = sync_q[1];
  assign tdi_s    = sync_q[2];
  assign trst_n_s = sync_q[3];

endmodule

// File: rtl/jtag_tap_sampled.sv
// rtl/jtag_tap_sampled.sv - IEEE 1149.1 TAP responder running on the system clock
//
// Purpose: oversampled JTAG TAP with 16-state FSM, instruction register,
// IDCODE, BYPASS and one user data register with SoC capture/update.
// Ports:
//   clk_in, reset        system clock, synchronous active-high reset
//   jtag_tck/tms/tdi     asynchronous JTAG pad inputs (sampled)
//   jtag_trst            asynchronous active-low TAP reset (sampled)
//   jtag_tdo, jtag_tdo_oe serial output and its enable (shift states only)
//   user_capture_data    parallel value loaded in Capture-DR for the user DR
//   user_update_valid    one-cycle pulse on Update-DR with the user opcode
//   user_update_data     last updated user DR value, held
//   tap_state            current FSM state for debug

module jtag_tap_sampled
  import jtag_tap_pkg::*;
#(
  parameter int                 IR_LEN       = 5,
  parameter logic [31:0]        IDCODE_VAL   = DEF_IDCODE_VAL,
  parameter int                 USER_DR_LEN  = 32,
  parameter logic [IR_LEN-1:0]  INSTR_IDCODE = IR_LEN'(DEF_INSTR_IDCODE),
  parameter logic [IR_LEN-1:0]  INSTR_USER   = IR_LEN'(DEF_INSTR_USER)
) (
  input  logic                   clk_in,
  input  logic                   reset,
  input  logic                   jtag_tck,
  input  logic                   jtag_tms,
  input  logic                   jtag_tdi,
  input  logic                   jtag_trst,
  output logic                   jtag_tdo,
  output logic                   jtag_tdo_oe,
  input  logic [USER_DR_LEN-1:0] user_capture_data,
  output logic                   user_update_valid,
  output logic [USER_DR_LEN-1:0] user_update_data,
  output logic [3:0]             tap_state
);

  localparam logic [IR_LEN-1:0] IR_CAPTURE = IR_LEN'(2'b01);

  logic tck_rise, tck_fall, tms_s, tdi_s, trst_n_s;

  jtag_in_sync u_sync (
    .clk_in    (clk_in),
    .reset     (reset),
    .jtag_tck  (jtag_tck),
    .jtag_tms  (jtag_tms),
    .jtag_tdi  (jtag_tdi),
    .jtag_trst (jtag_trst),
    .tck_rise  (tck_rise),
    .tck_fall  (tck_fall),
    .tms_s     (tms_s),
    .tdi_s     (tdi_s),
    .trst_n_s  (trst_n_s)
  );

  tap_state_e             state_q, state_d;
  logic [IR_LEN-1:0]      ir_q;
  logic [IR_LEN-1:0]      ir_shift_q;
  logic [31:0]            idcode_shift_q;
  logic                   bypass_q;
  logic [USER_DR_LEN-1:0] user_shift_q;
  logic                   tdo_q;
  logic                   tdo_oe_q;
  logic                   upd_valid_q;
  logic [USER_DR_LEN-1:0] upd_data_q;

  dr_sel_e dr_sel;
  logic    dr_lsb;

  assign state_d = next_state(state_q, tms_s);

  // DR selection follows the committed IR only; ir_shift never affects it.
  always_comb begin
    dr_sel = DR_BYPASS;
    if (ir_q == INSTR_IDCODE) begin
      dr_sel = DR_IDCODE;
    end else if (ir_q == INSTR_USER) begin
      dr_sel = DR_USER;
    end
  end

  always_comb begin
    dr_lsb = bypass_q;
    case (dr_sel)
      DR_IDCODE: dr_lsb = idcode_shift_q[0];
      DR_USER:   dr_lsb = user_shift_q[0];
      default:   dr_lsb = bypass_q;
    endcase
  end

  // trst and reset share one branch so they dominate any tck strobe
  // arriving in the same cycle.
  always_ff @(posedge clk_in) begin
    if (reset || !trst_n_s) begin
      state_q        <= TAP_TLR;
      ir_q           <= INSTR_IDCODE;
      ir_shift_q     <= '0;
      idcode_shift_q <= '0;
      bypass_q       <= 1'b0;
      user_shift_q   <= '0;
      tdo_q          <= 1'b0;
      tdo_oe_q       <= 1'b0;
      upd_valid_q    <= 1'b0;
      upd_data_q     <= '0;
    end else begin
      upd_valid_q <= 1'b0;

      // Rising tck: act on the state being left, then advance.
      if (tck_rise) begin
        case (state_q)
          TAP_CAP_IR: ir_shift_q <= IR_CAPTURE;
          TAP_SH_IR:  ir_shift_q <= {tdi_s, ir_shift_q[IR_LEN-1:1]};
          TAP_CAP_DR: begin
            case (dr_sel)
              DR_IDCODE: idcode_shift_q <= IDCODE_VAL;
              DR_USER:   user_shift_q   <= user_capture_data;
              default:   bypass_q       <= 1'b0;
            endcase
          end
          TAP_SH_DR: begin
            case (dr_sel)
              DR_IDCODE: idcode_shift_q <= {tdi_s, idcode_shift_q[31:1]};
              DR_USER:   user_shift_q   <= {tdi_s, user_shift_q[USER_DR_LEN-1:1]};
              default:   bypass_q       <= tdi_s;
            endcase
          end
          default: ;
        endcase
        state_q <= state_d;
        if (state_d == TAP_TLR) begin
          ir_q <= INSTR_IDCODE;
        end
      end

      // Falling tck: updates and tdo launch, so the host samples a stable
      // bit on the following rise.
      if (tck_fall) begin
        case (state_q)
          TAP_UPD_IR: begin
            ir_q     <= ir_shift_q;
            tdo_oe_q <= 1'b0;
          end
          TAP_UPD_DR: begin
            if (dr_sel == DR_USER) begin
              upd_data_q  <= user_shift_q;
              upd_valid_q <= 1'b1;
            end
            tdo_oe_q <= 1'b0;
          end
          TAP_SH_IR: begin
            tdo_q    <= ir_shift_q[0];
            tdo_oe_q <= 1'b1;
          end
          TAP_SH_DR: begin
            tdo_q    <= dr_lsb;
            tdo_oe_q <= 1'b1;
          end
          default: tdo_oe_q <= 1'b0;
        endcase
      end
    end
  end

  assign jtag_tdo          = tdo_q;
  assign jtag_tdo_oe       = tdo_oe_q;
  assign user_update_valid = upd_valid_q;
  assign user_update_data  = upd_data_q;
  assign tap_state         = state_q;

endmodule
